// File: rtl/nt_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nt_stim_pkg
// Purpose  : Shared constants, state encoding and step functions for the
//            Nt-node subcircuit stimulus / response-compaction engine.
//            - c_lfsr_taps    : Galois right-shift feedback taps
//            - c_misr_poly    : MISR feedback polynomial
//            - c_default_seed : substitute for an all-zero seed
//            - state_t        : engine FSM states
// Revision : 1.0 - initial release
// ============================================================================
package nt_stim_pkg;

    localparam logic [15:0] c_lfsr_taps    = 16'hB400;
    localparam logic [15:0] c_misr_poly    = 16'h1021;
    localparam logic [15:0] c_default_seed = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One Galois right-shift step of the pattern LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? c_lfsr_taps : 16'h0000);
    endfunction

    // One MISR compaction step folding in a single response bit.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? c_misr_poly : 16'h0000) ^ {15'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nt_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : nt_lfsr16
// Purpose  : 16-bit Galois pattern LFSR with synchronous parallel load.
// Ports    : clk_i    - clock, rising edge
//            rst_ni   - asynchronous active-low reset (state -> 0)
//            load_i   - load seed_i this edge (has priority over en_i)
//            seed_i   - value to load
//            en_i     - advance one step this edge
//            state_o  - current LFSR contents
// Revision : 1.0 - initial release
// ============================================================================
module nt_lfsr16
    import nt_stim_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= 16'h0000;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/nt_subckt_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : nt_subckt_stim_gen
// Purpose  : Drives pseudo-random vectors into a benchmark subcircuit and
//            compacts its one-bit responses into a 16-bit MISR signature.
// Ports    : I1470_clk  - clock, rising edge
//            I1477_rst  - asynchronous active-low reset
//            start      - run request, honoured in IDLE/DONE only
//            seed       - LFSR seed, sampled with start (0 -> 16'hACE1)
//            resp_in    - subcircuit response bit
//            vec_out    - applied vector (0 outside RUN)
//            vec_valid  - vec_out carries a live vector
//            busy       - RUN or DRAIN
//            done       - DONE, result held
//            signature  - MISR contents
//            vec_count  - vectors issued in the current run
// Revision : 1.0 - initial release
// ============================================================================
module nt_subckt_stim_gen
    import nt_stim_pkg::*;
#(
    parameter int VEC_W    = 3,
    parameter int LFSR_W   = 16,
    parameter int SIG_W    = 16,
    parameter int NUM_VEC  = 1000,
    parameter int PIPE_LAT = 1
) (
    input  logic              I1470_clk,
    input  logic              I1477_rst,
    input  logic              start,
    input  logic [LFSR_W-1:0] seed,
    input  logic              resp_in,
    output logic [VEC_W-1:0]  vec_out,
    output logic              vec_valid,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [15:0]       vec_count
);

    state_t             state_q;
    logic [VEC_W-1:0]   vec_out_q;
    logic               vec_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        vec_count_q;
    logic [2:0]         drain_cnt_q;
    logic [SIG_W-1:0]   sig_q;
    logic [SIG_W-1:0]   sig_d;
    logic [PIPE_LAT-1:0] valid_pipe_q;

    logic               w_start_ok;
    logic               w_last_vec;
    logic               w_capture;
    logic [15:0]        w_seed_eff;
    logic [15:0]        w_lfsr_state;
    logic               w_unused_lfsr_hi;

    assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_seed_eff = (seed == '0) ? c_default_seed : seed;
    // vec_count_q lags the vector on the pins by one, so the NUM_VEC-th
    // vector is on vec_out when the count reads NUM_VEC-1.
    assign w_last_vec = (vec_count_q == 16'(NUM_VEC - 1));
    assign w_capture  = valid_pipe_q[PIPE_LAT-1];

    // The seed vector is presented straight from the start edge, so the LFSR
    // is loaded one step ahead and always holds the *next* vector to issue.
    nt_lfsr16 u_lfsr (
        .clk_i   (I1470_clk),
        .rst_ni  (I1477_rst),
        .load_i  (w_start_ok),
        .seed_i  (lfsr_step(w_seed_eff)),
        .en_i    (state_q == ST_RUN),
        .state_o (w_lfsr_state)
    );

    assign w_unused_lfsr_hi = ^w_lfsr_state[15:VEC_W];

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            state_q     <= ST_IDLE;
            vec_out_q   <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vec_count_q <= 16'h0000;
            drain_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        vec_out_q   <= w_seed_eff[VEC_W-1:0];
                        vec_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        vec_count_q <= 16'h0000;
                        drain_cnt_q <= 3'd0;
                    end
                end
                ST_RUN: begin
                    vec_count_q <= vec_count_q + 16'd1;
                    if (w_last_vec) begin
                        state_q     <= ST_DRAIN;
                        vec_out_q   <= '0;
                        vec_valid_q <= 1'b0;
                        drain_cnt_q <= 3'd0;
                    end else begin
                        vec_out_q   <= w_lfsr_state[VEC_W-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 3'(PIPE_LAT - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Valid chain: tail marks the cycle whose resp_in belongs to a vector
    // ------------------------------------------------------------------
    generate
        if (PIPE_LAT == 1) begin : g_pipe_one
            always_ff @(posedge I1470_clk or negedge I1477_rst) begin
                if (!I1477_rst) begin
                    valid_pipe_q <= '0;
                end else begin
                    valid_pipe_q <= vec_valid_q;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge I1470_clk or negedge I1477_rst) begin
                if (!I1477_rst) begin
                    valid_pipe_q <= '0;
                end else begin
                    valid_pipe_q <= {valid_pipe_q[PIPE_LAT-2:0], vec_valid_q};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // MISR
    // ------------------------------------------------------------------
    always_comb begin
        sig_d = sig_q;
        if (w_start_ok) begin
            sig_d = '0;
        end else if (w_capture) begin
            sig_d = misr_step(sig_q, resp_in);
        end
    end

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign vec_out   = vec_out_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign vec_count = vec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nt_subckt_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_nt_subckt_stim_gen
// Purpose  : Directed self-checking bench for nt_subckt_stim_gen using three
//            parameterisations (A: 4 vec/lat 1, B: 3 vec/lat 1,
//            C: 20 vec/lat 3). Cycle k is the cycle following edge k, where
//            edge 0 samples start; outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nt_subckt_stim_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_start = 1'b0, a_resp = 1'b0;
    logic [15:0] a_seed  = 16'h0;
    logic [2:0]  a_vec;
    logic        a_vv, a_busy, a_done;
    logic [15:0] a_sig, a_cnt;

    logic        b_start = 1'b0, b_resp = 1'b0;
    logic [15:0] b_seed  = 16'h0;
    logic [2:0]  b_vec;
    logic        b_vv, b_busy, b_done;
    logic [15:0] b_sig, b_cnt;

    logic        c_start = 1'b0, c_resp = 1'b0;
    logic [15:0] c_seed  = 16'h0;
    logic [2:0]  c_vec;
    logic        c_vv, c_busy, c_done;
    logic [15:0] c_sig, c_cnt;

    nt_subckt_stim_gen #(.VEC_W(3), .LFSR_W(16), .SIG_W(16), .NUM_VEC(4), .PIPE_LAT(1)) u_a (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(a_start), .seed(a_seed), .resp_in(a_resp),
        .vec_out(a_vec), .vec_valid(a_vv), .busy(a_busy), .done(a_done),
        .signature(a_sig), .vec_count(a_cnt));

    nt_subckt_stim_gen #(.VEC_W(3), .LFSR_W(16), .SIG_W(16), .NUM_VEC(3), .PIPE_LAT(1)) u_b (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(b_start), .seed(b_seed), .resp_in(b_resp),
        .vec_out(b_vec), .vec_valid(b_vv), .busy(b_busy), .done(b_done),
        .signature(b_sig), .vec_count(b_cnt));

    nt_subckt_stim_gen #(.VEC_W(3), .LFSR_W(16), .SIG_W(16), .NUM_VEC(20), .PIPE_LAT(3)) u_c (
        .I1470_clk(clk), .I1477_rst(rst_n), .start(c_start), .seed(c_seed), .resp_in(c_resp),
        .vec_out(c_vec), .vec_valid(c_vv), .busy(c_busy), .done(c_done),
        .signature(c_sig), .vec_count(c_cnt));

    // Seed 0001: 0001 -> B400 -> 5A00 -> 2D00
    logic [2:0] seq_one  [4] = '{3'd1, 3'd0, 3'd0, 3'd0};
    // Seed ACE1: ACE1 -> E270 -> 7138 -> 389C
    logic [2:0] seq_ace1 [4] = '{3'd1, 3'd0, 3'd0, 3'd4};

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({a_vec, a_vv, a_busy, a_done} !== 6'b0) begin bad++; $display("FAIL reset_ctrl_a got=%b exp=000000", {a_vec, a_vv, a_busy, a_done}); end
        total++; if ({a_sig, a_cnt} !== 32'h0) begin bad++; $display("FAIL reset_data_a got=%h exp=00000000", {a_sig, a_cnt}); end
        total++; if ({b_vv, b_busy, b_done, c_vv, c_busy, c_done} !== 6'b0) begin bad++; $display("FAIL reset_ctrl_bc got=%b exp=000000", {b_vv, b_busy, b_done, c_vv, c_busy, c_done}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({a_busy, a_done, a_sig} !== 18'h0) begin bad++; $display("FAIL idle_after_reset got=%h exp=0", {a_busy, a_done, a_sig}); end
    endtask

    task automatic test_basic_seq();
        @(negedge clk); a_seed = 16'h0001; a_resp = 1'b0; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                total++; if (a_vv !== 1'b1 || a_vec !== seq_one[c-1]) begin bad++; $display("FAIL seq1_vec c=%0d got=%0d/%0d exp=1/%0d", c, a_vv, a_vec, seq_one[c-1]); end
                total++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin bad++; $display("FAIL seq1_busy c=%0d got=%b%b exp=10", c, a_busy, a_done); end
            end else if (c == 5) begin
                total++; if ({a_vv, a_vec, a_busy, a_done} !== 6'b000010) begin bad++; $display("FAIL seq1_drain got=%b exp=000010", {a_vv, a_vec, a_busy, a_done}); end
            end else begin
                total++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL seq1_done got=%b%b exp=01", a_busy, a_done); end
                total++; if (a_sig !== 16'h0000) begin bad++; $display("FAIL seq1_sig got=%h exp=0000", a_sig); end
                total++; if (a_cnt !== 16'd4) begin bad++; $display("FAIL seq1_cnt got=%0d exp=4", a_cnt); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_seed_zero();
        @(negedge clk); a_seed = 16'h0000; a_resp = 1'b1; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                total++; if (a_vec !== seq_ace1[c-1]) begin bad++; $display("FAIL ace1_vec c=%0d got=%0d exp=%0d", c, a_vec, seq_ace1[c-1]); end
            end
            if (c == 3) begin
                total++; if (a_sig !== 16'h0001) begin bad++; $display("FAIL ace1_sig_c3 got=%h exp=0001", a_sig); end
            end
            if (c == 6) begin
                total++; if (a_sig !== 16'h000F || a_done !== 1'b1) begin bad++; $display("FAIL ace1_final got=%h/%b exp=000f/1", a_sig, a_done); end
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        total++; if (a_sig !== 16'h000F || a_cnt !== 16'd4 || a_done !== 1'b1) begin bad++; $display("FAIL done_hold got=%h/%0d/%b exp=000f/4/1", a_sig, a_cnt, a_done); end
    endtask

    task automatic test_misr_ones();
        @(negedge clk); b_seed = 16'h0005; b_resp = 1'b1; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin
                total++; if (b_vec !== 3'd5) begin bad++; $display("FAIL ones_first_vec got=%0d exp=5", b_vec); end
            end
            if (c == 3) begin
                total++; if (b_sig !== 16'h0001) begin bad++; $display("FAIL ones_sig_c3 got=%h exp=0001", b_sig); end
            end
            if (c == 4) begin
                total++; if (b_sig !== 16'h0003 || b_done !== 1'b0 || b_busy !== 1'b1) begin bad++; $display("FAIL ones_c4 got=%h/%b%b exp=0003/10", b_sig, b_busy, b_done); end
            end
            if (c == 5) begin
                total++; if (b_sig !== 16'h0007 || b_cnt !== 16'd3 || b_done !== 1'b1) begin bad++; $display("FAIL ones_final got=%h/%0d/%b exp=0007/3/1", b_sig, b_cnt, b_done); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_in_run();
        @(negedge clk); b_seed = 16'h0002; b_resp = 1'b1; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            b_start = (c == 2);
            if (c == 4) begin
                total++; if (b_vv !== 1'b0) begin bad++; $display("FAIL norestart_vv got=%b exp=0", b_vv); end
            end
            if (c == 5) begin
                total++; if (b_sig !== 16'h0007 || b_cnt !== 16'd3 || b_done !== 1'b1) begin bad++; $display("FAIL norestart_final got=%h/%0d/%b exp=0007/3/1", b_sig, b_cnt, b_done); end
            end
            @(negedge clk);
        end
        b_start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk); b_seed = 16'h0003; b_resp = 1'b1; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({b_vec, b_vv, b_busy, b_done} !== 6'b0) begin bad++; $display("FAIL midrst_ctrl got=%b exp=000000", {b_vec, b_vv, b_busy, b_done}); end
        total++; if ({b_sig, b_cnt} !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h exp=00000000", {b_sig, b_cnt}); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (b_sig !== 16'h0007 || b_cnt !== 16'd3 || b_done !== 1'b1) begin bad++; $display("FAIL midrst_rerun got=%h/%0d/%b exp=0007/3/1", b_sig, b_cnt, b_done); end
    endtask

    task automatic test_pipe3_masked();
        @(negedge clk); c_seed = 16'h0001; c_resp = 1'b1; c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            c_resp = (c <= 3);
            if (c == 20) begin
                total++; if (c_vv !== 1'b1) begin bad++; $display("FAIL p3_last_valid got=%b exp=1", c_vv); end
            end
            if (c == 21) begin
                total++; if (c_vv !== 1'b0 || c_vec !== 3'd0) begin bad++; $display("FAIL p3_drain_vec got=%b/%0d exp=0/0", c_vv, c_vec); end
            end
            if (c == 23) begin
                total++; if (c_busy !== 1'b1 || c_done !== 1'b0) begin bad++; $display("FAIL p3_c23 got=%b%b exp=10", c_busy, c_done); end
            end
            if (c == 24) begin
                total++; if (c_busy !== 1'b0 || c_done !== 1'b1) begin bad++; $display("FAIL p3_done got=%b%b exp=01", c_busy, c_done); end
                total++; if (c_sig !== 16'h0000 || c_cnt !== 16'd20) begin bad++; $display("FAIL p3_masked_sig got=%h/%0d exp=0000/20", c_sig, c_cnt); end
            end
            @(negedge clk);
        end
        c_resp = 1'b0;
    endtask

    task automatic test_pipe3_ones();
        // 20 captured ones: 16 steps reach FFFF, then EFDE, CF9C, 8F18, 0E10.
        @(negedge clk); c_seed = 16'h1234; c_resp = 1'b1; c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
        repeat (23) @(negedge clk);
        total++; if (c_sig !== 16'h0E10 || c_done !== 1'b1 || c_cnt !== 16'd20) begin bad++; $display("FAIL p3_ones got=%h/%b/%0d exp=0e10/1/20", c_sig, c_done, c_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_seq();
        test_seed_zero();
        test_misr_ones();
        test_start_in_run();
        test_reset_mid_run();
        test_pipe3_masked();
        test_pipe3_ones();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nt_subckt_stim_gen.md
# nt_subckt_stim_gen

Stimulus and response-compaction engine for Nt-node benchmark subcircuits. It drives pseudo-random input vectors into a device-under-test subcircuit and folds the subcircuit's single-bit output into a MISR signature. It sits opposite the subcircuit on the same pin set: the subcircuit receives vectors and returns one response bit per vector. Golden-versus-suspect signature comparison happens outside this block.

## Interface
- `VEC_W`, default 3: number of subcircuit data inputs driven.
- `LFSR_W`, default 16: pattern LFSR width; fixed at 16 because the taps are fixed.
- `SIG_W`, default 16: MISR width; fixed at 16.
- `NUM_VEC`, default 1000: vectors per run, range 1..65535.
- `PIPE_LAT`, default 1: cycles from `vec_out` presentation to a valid `resp_in`, range 1..4.

Ports, clock and reset first:
- `I1470_clk`, in, 1: single clock; all flops rise-edge.
- `I1477_rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle run request; honoured only in IDLE or DONE.
- `seed`, in, 16: LFSR seed, sampled with `start`.
- `resp_in`, in, 1: subcircuit output.
- `vec_out`, out, VEC_W: applied vector.
- `vec_valid`, out, 1: `vec_out` is a live vector this cycle.
- `busy`, out, 1: high in RUN or DRAIN.
- `done`, out, 1: high in DONE.
- `signature`, out, 16: MISR contents.
- `vec_count`, out, 16: vectors issued in the current run.

## Operation
- States:
  - IDLE: after reset.
  - RUN: issue vectors.
  - DRAIN: wait for the last responses.
  - DONE: result held.
- Reset value of every output is 0, and the state is IDLE.
- Start, in IDLE or DONE with `start`=1:
  - load the LFSR with `seed`; if `seed`==0, load 16'hACE1 instead;
  - clear the MISR and `vec_count`;
  - go to RUN.
- `start` is ignored in RUN and DRAIN.
- RUN, each cycle:
  - `vec_out` = lfsr[VEC_W-1:0] and `vec_valid`=1;
  - the LFSR advances one Galois right-shift step: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0);
  - `vec_count` increments.
- When the NUM_VEC-th vector is issued, the next state is DRAIN.
- Valid tracking: a PIPE_LAT-deep shift register carries `vec_valid`. When its tail is 1, `resp_in` is captured into the MISR.
- MISR update: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, resp_in}.
- DRAIN:
  - `vec_valid`=0 and `vec_out` is held at 0;
  - lasts exactly PIPE_LAT cycles, then the state moves to DONE.
- DONE:
  - `done`=1;
  - `signature` and `vec_count` are held;
  - a new `start` restarts immediately from IDLE-equivalent behaviour.
- Reset mid-run: asynchronous return to IDLE. All state is cleared; no partial signature is preserved.
- `resp_in` is ignored whenever the valid-chain tail is 0. This includes IDLE, DONE, and the first PIPE_LAT cycles of RUN.

## Timing
- `start` is sampled at edge 0. The first vector appears on cycle 1 with `vec_out` = seed[VEC_W-1:0], or 3'b001 when the 16'hACE1 substitute is used.
- Exactly NUM_VEC consecutive `vec_valid` cycles occur, on cycles 1..NUM_VEC.
- The response to vector k, issued on cycle k, is captured at the edge ending cycle k+PIPE_LAT.
- `done` rises on cycle NUM_VEC+PIPE_LAT+1. `busy` falls on the same cycle.
- Every output is registered; there is no combinational path from any input to any output.

## Structure
- Package `nt_stim_pkg` holds:
  - LFSR taps 16'hB400;
  - MISR polynomial 16'h1021;
  - default seed 16'hACE1;
  - the state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, `nt_lfsr16`, provides:
  - a load-with-seed input;
  - an enable;
  - the parallel state output.
- The MISR, valid chain, counter and FSM stay in the top module.

## Test plan
- Seed 16'h0001, NUM_VEC=4, PIPE_LAT=1, `resp_in`=0:
  - `vec_out` sequence is 1, 0, 0, 0 (LFSR 0001→B400→5A00→2D00);
  - `signature`=16'h0000;
  - `done` rises on cycle 6.
- NUM_VEC=3, `resp_in`=1 constant:
  - `signature` steps 0001→0003→0007;
  - final value 16'h0007;
  - `vec_count`=3.
- Seed 0: the first `vec_out` is 3'b001, confirming the ACE1 substitution.
- `start` pulsed during RUN: no restart; the vector count and signature match an unpulsed run.
- `I1477_rst` low mid-RUN: all outputs read 0 on the same cycle. A new `start` after release reproduces the full-run signature.
- PIPE_LAT=3, `resp_in` held at 1 for cycles 1..3 only (before any capture) and then 0: `signature`=16'h0000.
